// File: rtl/cap_prop_check_sched.sv
// Sequences capability property checks over one shared checker and gathers a pass/fail mask per vector.
// Optional macro CAP_PROP_STOP_ON_FAIL_EN: end the vector at the first failed or timed-out property.
module cap_prop_check_sched #(
    parameter int NUM_PROPS   = 9,
    parameter int SEL_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_base,
    input  logic [63:0]          in_len,
    input  logic [63:0]          in_addr,
    input  logic [NUM_PROPS-1:0] in_prop_en,
    output logic                 chk_req_valid,
    output logic [SEL_W-1:0]     chk_sel,
    output logic [63:0]          chk_base,
    output logic [63:0]          chk_len,
    output logic [63:0]          chk_addr,
    input  logic                 chk_rsp_valid,
    input  logic                 chk_rsp_ok,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NUM_PROPS-1:0] res_fail_mask,
    output logic                 res_timeout,
    output logic [31:0]          vec_count,
    output logic [31:0]          fail_count
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [NUM_PROPS-1:0] en_q, en_d;
    logic [NUM_PROPS-1:0] mask_q, mask_d;
    logic                 to_q, to_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [63:0]          base_q, base_d, len_q, len_d, addr_q, addr_d;
    logic [31:0]          vec_q, vec_d, fail_q, fail_d;
    logic                 resolve, fail_now, last_prop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            en_q    <= '0;
            mask_q  <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            vec_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            mask_q  <= mask_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            vec_q   <= vec_d;
            fail_q  <= fail_d;
        end
    end

    assign last_prop = (idx_q == SEL_W'(NUM_PROPS - 1));

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        en_d          = en_q;
        mask_d        = mask_q;
        to_d          = to_q;
        cnt_d         = '0;
        base_d        = base_q;
        len_d         = len_q;
        addr_d        = addr_q;
        vec_d         = vec_q;
        fail_d        = fail_q;
        chk_req_valid = 1'b0;
        resolve       = 1'b0;
        fail_now      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    base_d  = in_base;
                    len_d   = in_len;
                    addr_d  = in_addr;
                    en_d    = in_prop_en;
                    idx_d   = '0;
                    mask_d  = '0;
                    to_d    = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!en_q[idx_q]) begin
                    resolve = 1'b1;
                end else begin
                    chk_req_valid = 1'b1;
                    // A response in the final allowed cycle takes priority over the timeout.
                    if (chk_rsp_valid) begin
                        mask_d[idx_q] = ~chk_rsp_ok;
                        fail_now      = ~chk_rsp_ok;
                        resolve       = 1'b1;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        mask_d[idx_q] = 1'b1;
                        to_d          = 1'b1;
                        fail_now      = 1'b1;
                        resolve       = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (resolve) begin
`ifdef CAP_PROP_STOP_ON_FAIL_EN
                    state_d = (last_prop || fail_now) ? S_DONE : S_STEP;
`else
                    state_d = last_prop ? S_DONE : S_STEP;
`endif
                end
            end
            S_STEP: begin
                idx_d   = idx_q + 1'b1;
                state_d = S_WAIT;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                    if (vec_q != '1) vec_d = vec_q + 1'b1;
                    if ((mask_q != '0) && (fail_q != '1)) fail_d = fail_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready      = (state_q == S_IDLE);
    assign res_valid     = (state_q == S_DONE);
    assign chk_sel       = chk_req_valid ? idx_q : '0;
    assign chk_base      = base_q;
    assign chk_len       = len_q;
    assign chk_addr      = addr_q;
    assign res_fail_mask = mask_q;
    assign res_timeout   = to_q;
    assign vec_count     = vec_q;
    assign fail_count    = fail_q;

endmodule

// File: tb/tb_cap_prop_check_sched.sv
// Scoreboard bench for cap_prop_check_sched: a checker responder follows a per-vector plan,
// a reference model predicts mask/timeout/latency, and a monitor compares each result record.
`timescale 1ns/1ps
module tb_cap_prop_check_sched;
    localparam int NP = 9;
    localparam int SW = 4;
    localparam int TO = 16;
    localparam int SILENT = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready;
    logic [63:0]   in_base, in_len, in_addr;
    logic [NP-1:0] in_prop_en;
    logic          chk_req_valid;
    logic [SW-1:0] chk_sel;
    logic [63:0]   chk_base, chk_len, chk_addr;
    logic          chk_rsp_valid, chk_rsp_ok;
    logic          res_valid, res_ready;
    logic [NP-1:0] res_fail_mask;
    logic          res_timeout;
    logic [31:0]   vec_count, fail_count;

    cap_prop_check_sched #(.NUM_PROPS(NP), .SEL_W(SW), .TIMEOUT_CYC(TO)) dut (
        .CLK(clk), .RST_N(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_len(in_len), .in_addr(in_addr), .in_prop_en(in_prop_en),
        .chk_req_valid(chk_req_valid), .chk_sel(chk_sel),
        .chk_base(chk_base), .chk_len(chk_len), .chk_addr(chk_addr),
        .chk_rsp_valid(chk_rsp_valid), .chk_rsp_ok(chk_rsp_ok),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_fail_mask(res_fail_mask), .res_timeout(res_timeout),
        .vec_count(vec_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NP-1:0] mask;
        logic          to;
        int            res_cyc;
        int            nreq;
        int            vec;
        int            fail;
        logic [63:0]   base;
        logic [63:0]   len;
        logic [63:0]   addr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Plan for the next vector (pend_*) and for the vector the DUT is working on (act_*).
    int            pend_dly[NP];
    bit            pend_ok[NP];
    int            act_dly[NP];
    bit            act_ok[NP];
    logic [NP-1:0] act_en = '0;
    logic [63:0]   act_base = '0, act_len = '0, act_addr = '0;
    int            req_starts = 0;
    int            m_vec = 0, m_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: each property costs its waiting cycles, plus one STEP between properties
    // and the final cycle reaching DONE.
    function automatic void predict(input logic [NP-1:0] en, output logic [NP-1:0] mask,
                                    output logic to, output int lat, output int nreq);
        int nev;
        bit stop;
        mask = '0; to = 1'b0; lat = 0; nreq = 0; nev = 0; stop = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (!stop) begin
                nev++;
                if (!en[i]) begin
                    lat += 1;
                end else begin
                    nreq++;
                    if (pend_dly[i] < TO) begin
                        lat += pend_dly[i] + 1;
                        mask[i] = !pend_ok[i];
                    end else begin
                        lat += TO;
                        mask[i] = 1'b1;
                        to = 1'b1;
                    end
`ifdef CAP_PROP_STOP_ON_FAIL_EN
                    if (mask[i]) stop = 1'b1;
`endif
                end
            end
        end
        lat += nev;
    endfunction

    task automatic set_all(input int dly, input bit ok);
        for (int i = 0; i < NP; i++) begin
            pend_dly[i] = dly;
            pend_ok[i]  = ok;
        end
    endtask

    task automatic issue(input logic [NP-1:0] en, input bit push);
        exp_t e;
        int lat, k, acc;
        e.base = {$urandom, $urandom};
        e.len  = {$urandom, $urandom};
        e.addr = {$urandom, $urandom};
        predict(en, e.mask, e.to, lat, e.nreq);
        @(negedge clk);
        in_valid = 1'b1; in_base = e.base; in_len = e.len; in_addr = e.addr; in_prop_en = en;
        k = 0;
        while (!in_ready) begin
            @(negedge clk);
            k++;
            if (k > 1000) begin
                chk("accept_wait_expired", 64'(k), 64'(0));
                in_valid = 1'b0;
                return;
            end
        end
        acc = cyc;
        @(posedge clk);
        act_dly = pend_dly; act_ok = pend_ok; act_en = en;
        act_base = e.base; act_len = e.len; act_addr = e.addr;
        if (push) begin
            m_vec++;
            if (e.mask != '0) m_fail++;
            e.vec = m_vec; e.fail = m_fail; e.res_cyc = acc + lat;
            exp_q.push_back(e);
        end
        $display("issue en=%03h base=%016h accept_cycle=%0d push=%0d", en, e.base, acc, push);
        @(negedge clk);
        in_valid = 1'b0;
        in_base = {$urandom, $urandom}; in_len = {$urandom, $urandom}; in_addr = {$urandom, $urandom};
        in_prop_en = NP'($urandom);
    endtask

    // Checker responder: answers on the planned asserted cycle, strays when no request is up.
    initial begin : responder
        bit prev;
        int cnt;
        prev = 1'b0; cnt = 0; chk_rsp_valid = 1'b0; chk_rsp_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && chk_req_valid) begin
                if (!prev) begin
                    cnt = 1;
                    req_starts++;
                    chk("req_sel_enabled", 64'(act_en[chk_sel]), 64'(1));
                    chk("req_base", chk_base, act_base);
                    chk("req_len", chk_len, act_len);
                    chk("req_addr", chk_addr, act_addr);
                end else begin
                    cnt++;
                end
                prev = 1'b1;
                if (cnt == act_dly[chk_sel] + 1) begin
                    chk_rsp_valid = 1'b1;
                    chk_rsp_ok    = act_ok[chk_sel];
                end else begin
                    chk_rsp_valid = 1'b0;
                    chk_rsp_ok    = 1'($urandom);
                end
            end else begin
                prev = 1'b0;
                chk_rsp_valid = ($urandom_range(0, 3) == 0);
                chk_rsp_ok    = 1'($urandom);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int hold, nres, req_base;
        nres = 0; req_base = 0; res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(1), 64'(0));
                    res_ready = 1'b1;
                    @(negedge clk);
                    res_ready = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    $display("result #%0d cycle=%0d mask=%03h timeout=%0d (want cycle=%0d mask=%03h timeout=%0d)",
                             nres, cyc, res_fail_mask, res_timeout, e.res_cyc, e.mask, e.to);
                    chk("res_cycle", 64'(cyc), 64'(e.res_cyc));
                    chk("res_fail_mask", 64'(res_fail_mask), 64'(e.mask));
                    chk("res_timeout", 64'(res_timeout), 64'(e.to));
                    chk("req_count", 64'(req_starts - req_base), 64'(e.nreq));
                    hold = (nres < 6) ? 5 : $urandom_range(0, 3);
                    for (int k = 0; k < hold; k++) begin
                        chk("bp_hold", {51'b0, res_valid, in_ready, chk_req_valid, res_timeout, res_fail_mask},
                            {51'b0, 1'b1, 1'b0, 1'b0, e.to, e.mask});
                        chk("bp_operands", chk_base ^ chk_len ^ chk_addr, e.base ^ e.len ^ e.addr);
                        @(negedge clk);
                    end
                    res_ready = 1'b1;
                    @(negedge clk);
                    res_ready = 1'b0;
                    chk("post_accept_idle", {62'b0, in_ready, res_valid}, 64'b10);
                    chk("vec_count", 64'(vec_count), 64'(e.vec));
                    chk("fail_count", 64'(fail_count), 64'(e.fail));
                    req_base = req_starts;
                    nres++;
                end
            end
        end
    end

    initial begin : main
        logic [NP-1:0] en;
        int r, k, seen;
        in_valid = 1'b0; in_base = '0; in_len = '0; in_addr = '0; in_prop_en = '0;
        set_all(0, 1'b1);
        repeat (3) @(negedge clk);
        chk("reset_ready_req_res", {60'b0, in_ready, chk_req_valid, res_valid, res_timeout}, 64'b1000);
        chk("reset_sel_mask", {51'b0, chk_sel, res_fail_mask}, 64'(0));
        chk("reset_operands", chk_base | chk_len | chk_addr, 64'(0));
        chk("reset_counters", {vec_count, fail_count}, 64'(0));
        rst_n = 1'b1;

        set_all(0, 1'b1);                      issue('1, 1'b1);
        set_all(0, 1'b1); pend_ok[4] = 1'b0;   issue('1, 1'b1);
        set_all(0, 1'b1); pend_dly[2] = SILENT; issue('1, 1'b1);
        set_all(0, 1'b1); pend_dly[2] = TO - 1; issue('1, 1'b1);
        set_all(0, 1'b1);                      issue(9'h101, 1'b1);
        set_all(0, 1'b0);                      issue('0, 1'b1);

        for (int v = 0; v < 30; v++) begin
            for (int i = 0; i < NP; i++) begin
                r = $urandom_range(0, 9);
                pend_dly[i] = (r < 6) ? $urandom_range(0, 3) : (r < 9) ? $urandom_range(4, TO - 1) : SILENT;
                pend_ok[i]  = ($urandom_range(0, 4) != 0);
            end
            en = NP'($urandom | $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(en, 1'b1);
        end

        k = 0;
        while (exp_q.size() != 0 || !in_ready) begin
            @(negedge clk);
            k++;
            if (k > 3000) begin
                chk("drain_expired", 64'(k), 64'(0));
                break;
            end
        end

        // Reset in the middle of the request for property 3.
        set_all(2, 1'b1);
        issue('1, 1'b0);
        k = 0;
        while (!(chk_req_valid && chk_sel == SW'(3))) begin
            @(negedge clk);
            k++;
            if (k > 200) begin
                chk("sel3_wait_expired", 64'(k), 64'(0));
                break;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_ready_req_res", {60'b0, in_ready, chk_req_valid, res_valid, res_timeout}, 64'b1000);
        chk("midreset_sel_mask", {51'b0, chk_sel, res_fail_mask}, 64'(0));
        chk("midreset_operands", chk_base | chk_len | chk_addr, 64'(0));
        chk("midreset_counters", {vec_count, fail_count}, 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid || chk_req_valid) seen++;
        end
        chk("no_activity_after_reset", 64'(seen), 64'(0));
        chk("counters_after_reset", {vec_count, fail_count}, 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cap_prop_check_sched.md
Name: cap_prop_check_sched

Overview:
- Scheduler that sequences the CHERI capability property checkers (unique, exact, exactConditions, getBase, getTop, getLength, isInBounds, hasAlmightyBounds, setAddr, ...) over one shared checker datapath.
- Accepts one operand vector (base, len, addr) at a time. Issues one request per enabled property, collects pass/fail into a mask, and reports a result record.
- Keeps saturating vector and failure counters for the formal/simulation harness.

Parameters:
- NUM_PROPS, 9, number of property selects issued per vector (select values 0..NUM_PROPS-1).
- SEL_W, 4, width of chk_sel; must satisfy 2^SEL_W >= NUM_PROPS.
- TIMEOUT_CYC, 16, maximum cycles a request stays asserted without a response (>=2).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  operand vector offered.
- in_ready  out  1  high only in IDLE.
- in_base  in  64  capability base.
- in_len  in  64  capability length.
- in_addr  in  64  address operand.
- in_prop_en  in  NUM_PROPS  per-property enable, sampled at accept.
- chk_req_valid  out  1  request to the shared checker.
- chk_sel  out  SEL_W  property index of the current request.
- chk_base  out  64  latched base, held for the whole vector.
- chk_len  out  64  latched length.
- chk_addr  out  64  latched address.
- chk_rsp_valid  in  1  checker response strobe.
- chk_rsp_ok  in  1  property held; qualified by chk_rsp_valid.
- res_valid  out  1  result record available.
- res_ready  in  1  consumer takes the result.
- res_fail_mask  out  NUM_PROPS  bit i set if property i failed or timed out.
- res_timeout  out  1  at least one request timed out.
- vec_count  out  32  vectors completed; saturating.
- fail_count  out  32  vectors with a nonzero fail mask; saturating.

Behaviour:
- Reset (async, RST_N low): state IDLE, in_ready=1, chk_req_valid=0, chk_sel=0, chk_base/len/addr=0, res_valid=0, res_fail_mask=0, res_timeout=0, vec_count=0, fail_count=0. Reset mid-vector aborts the vector with no result.
- States: IDLE, WAIT, STEP, DONE.
- IDLE
  - On in_valid&in_ready: latch operands and in_prop_en; idx=0; mask=0; timeout flag=0; go to WAIT.
- WAIT (idx = current property)
  - If en[idx]=0: chk_req_valid=0, property skipped, mask bit stays 0.
  - If en[idx]=1: chk_req_valid=1, chk_sel=idx.
  - Response: chk_rsp_valid sampled the same cycle the request is high (zero-latency checker allowed); mask[idx]=~chk_rsp_ok.
  - Timeout: wait counter cleared on entry to WAIT. If no response by the TIMEOUT_CYC-th asserted cycle, set mask[idx]=1 and the timeout flag. A response arriving in that same cycle wins over the timeout.
  - Exit on resolution (response, timeout or skip): if idx==NUM_PROPS-1 go to DONE, else go to STEP.
- STEP
  - One cycle, chk_req_valid=0 (delimits requests); idx++; go to WAIT.
- chk_rsp_valid outside an asserted request is ignored.
- DONE
  - res_valid=1; res_fail_mask and res_timeout stable until accepted.
  - On res_ready: go to IDLE; vec_count+=1; fail_count+=1 if mask!=0. Both counters saturate at 0xFFFF_FFFF.
- Latency: with all properties enabled and instant responses, acceptance at cycle 0 gives requests at cycles 1,3,...,2*NUM_PROPS-1 and res_valid at cycle 2*NUM_PROPS (18 for default).
- A skipped property costs the same 2 cycles, so an all-disabled vector also gives res_valid at cycle 18 with mask 0.
- Operand outputs never change between acceptance and result acceptance.

Optional Feature:
- Macro: CAP_PROP_STOP_ON_FAIL_EN.
- Defined: after the first failed or timed-out property, go directly to DONE (no STEP). Remaining properties are not requested and their mask bits stay 0.
- Undefined: all NUM_PROPS properties are always evaluated as above.

Test Plan:
- All enabled, checker returns ok=1 same cycle: requests at cycles 1,3,...,17 with chk_sel 0..8; res_valid at cycle 18; mask=0x000; vec_count=1; fail_count=0.
- ok=0 only for sel=4: mask=0x010, res_timeout=0, fail_count=1. With CAP_PROP_STOP_ON_FAIL_EN: mask=0x010, res_valid at cycle 10, no requests with sel>4.
- Checker silent for sel=2: request held exactly 16 cycles, then mask bit2=1 and res_timeout=1. Response on the 16th cycle with ok=1 gives mask bit2=0 and res_timeout=0.
- in_prop_en=0x101: requests only for sel 0 and 8; res_valid at cycle 18; disabled bits 0.
- Backpressure: res_ready low 5 cycles after res_valid. Outputs stable, in_ready=0, new in_valid not accepted. Acceptance next cycle gives IDLE with in_ready=1.
- RST_N asserted during WAIT (sel=3): all outputs immediately return to reset values, counters 0, no res_valid after release.
